hni_rxdat_fifo: RTL and testbench
=================================

HNI_RXDAT_FIFO -- requirements
Module: hni_rxdat_fifo

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 4, as the number of DAT flit entries; the value SHALL be a power of two, at least 2.
REQ-002 The block SHALL take parameter PTR_W, default 2, as the pointer width, equal to log2(FIFO_DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rxdat_valid_s0, input, 1 bit: a DAT flit is present this cycle, from hni_rxdat.
REQ-006 The block SHALL have port rxdatflit_s0, input, `CHIE_DAT_FLIT_WIDTH bits: the DAT flit payload from hni_rxdat.
REQ-007 The block SHALL have port dbf_rxdat_valid, output, 1 bit: a head flit is available to hni_data_buffer.
REQ-008 The block SHALL have port dbf_rxdatflit, output, `CHIE_DAT_FLIT_WIDTH bits: the head flit payload.
REQ-009 The block SHALL have port dbf_rxdat_ready, input, 1 bit: hni_data_buffer accepts the head flit this cycle.
REQ-010 The block SHALL have port rxdat_fifo_cnt, output, PTR_W+1 bits: the current occupancy.
REQ-011 The block SHALL have port rxdat_fifo_full, output, 1 bit: occupancy equals FIFO_DEPTH.
REQ-012 The block SHALL have port rxdat_fifo_ovf, output, 1 bit: sticky flag, set when a flit was dropped.

Function
REQ-013 Push SHALL equal rxdat_valid_s0 AND (NOT full OR pop); a push SHALL write the flit to mem[wr_ptr] and increment wr_ptr modulo FIFO_DEPTH.
REQ-014 Pop SHALL equal dbf_rxdat_valid AND dbf_rxdat_ready; a pop SHALL increment rd_ptr modulo FIFO_DEPTH.
REQ-015 The block SHALL be show-ahead: dbf_rxdat_valid equals (count != 0) and dbf_rxdatflit equals mem[rd_ptr]; when the FIFO is empty, dbf_rxdatflit SHALL be all zeros.
REQ-016 Count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-017 Without the bypass (REQ-025), write-to-read latency SHALL be 1 cycle: a flit pushed in cycle N is visible on dbf_rxdat_valid in cycle N+1.
REQ-018 When full, without a pop, and rxdat_valid_s0=1, the flit SHALL be dropped, the state SHALL be left unchanged, and rxdat_fifo_ovf SHALL be set in the next cycle and held until reset.
REQ-019 When full with a simultaneous pop and push, the push SHALL be accepted, count SHALL stay FIFO_DEPTH, and no overflow SHALL be flagged.
REQ-020 A pop while empty SHALL not occur, because valid is 0; dbf_rxdat_ready while empty SHALL be ignored.
REQ-021 Pointer wrap SHALL be seamless: after FIFO_DEPTH pushes, wr_ptr returns to 0, and data order SHALL be strictly FIFO.
REQ-022 rxdat_fifo_full SHALL be derived from count, not from a pointer compare.

Reset
REQ-023 On rst_n=0 the block SHALL immediately set wr_ptr=0, rd_ptr=0, count=0 and rxdat_fifo_ovf=0, giving dbf_rxdat_valid=0, dbf_rxdatflit=0, rxdat_fifo_cnt=0 and rxdat_fifo_full=0; the storage array SHALL not be reset.
REQ-024 Reset asserted mid-operation SHALL discard all held flits; the first push after rst_n deasserts SHALL land at entry 0.

Configuration
REQ-025 When macro HNI_RXDAT_FIFO_BYPASS_EN is defined, the block SHALL behave as follows whenever the FIFO is empty and rxdat_valid_s0=1:
- dbf_rxdat_valid=1 and dbf_rxdatflit=rxdatflit_s0 in the same cycle (0-cycle latency);
- if dbf_rxdat_ready=1, the flit SHALL be consumed without being written, and count SHALL stay 0;
- otherwise it SHALL be pushed normally.
REQ-026 When HNI_RXDAT_FIFO_BYPASS_EN is undefined, no combinational path SHALL exist from rxdat_valid_s0 or rxdatflit_s0 to the dbf_* outputs.

Verification
REQ-027 Reset, then push flits A, B, C with ready=0 -> cnt=3 and head=A; assert ready for 3 cycles -> A, B, C emerge in order, then cnt=0 and valid=0.
REQ-028 With FIFO_DEPTH=4, push 5 flits with ready=0 -> full=1, cnt=4, the 5th flit is dropped, ovf=1 from the next cycle, and the head is still flit 1.
REQ-029 When full with ready=1 and valid=1 in the same cycle -> cnt stays 4, ovf stays 0, and the new flit emerges 4th in order.
REQ-030 Stream 10 flits with ready=1 continuously -> all 10 flits delivered in order, pointers wrap past 3 to 0, cnt never exceeds 1, latency 1 cycle (0 cycles with HNI_RXDAT_FIFO_BYPASS_EN).
REQ-031 Push 2 flits, then drive rst_n low asynchronously between clock edges -> valid=0, cnt=0 and ovf=0 immediately; the next push after release reads back correctly.
REQ-032 With HNI_RXDAT_FIFO_BYPASS_EN defined, empty FIFO, valid=1 and ready=1 with flit 0x5A -> dbf_rxdatflit=0x5A in the same cycle and cnt remains 0; repeat with ready=0 -> cnt=1 next cycle.

Source files
------------

// File: rtl/hni_rxdat_fifo_if.sv
// hni_rxdat_fifo_if: groups the RXDAT ingress, the data-buffer egress and the
// FIFO status signals of hni_rxdat_fifo. Signal names match the original
// module ports.
// CHIE_DAT_FLIT_WIDTH falls back to 64 when the build does not define it.

`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 64
`endif

interface hni_rxdat_fifo_if #(
  parameter int unsigned PTR_W = 2
);
  logic                            rxdat_valid_s0;
  logic [`CHIE_DAT_FLIT_WIDTH-1:0] rxdatflit_s0;
  logic                            dbf_rxdat_valid;
  logic [`CHIE_DAT_FLIT_WIDTH-1:0] dbf_rxdatflit;
  logic                            dbf_rxdat_ready;
  logic [PTR_W:0]                  rxdat_fifo_cnt;
  logic                            rxdat_fifo_full;
  logic                            rxdat_fifo_ovf;

  // Environment side: hni_rxdat producer plus hni_data_buffer consumer.
  modport master (
    output rxdat_valid_s0, rxdatflit_s0, dbf_rxdat_ready,
    input  dbf_rxdat_valid, dbf_rxdatflit,
    input  rxdat_fifo_cnt, rxdat_fifo_full, rxdat_fifo_ovf
  );

  // FIFO side.
  modport slave (
    input  rxdat_valid_s0, rxdatflit_s0, dbf_rxdat_ready,
    output dbf_rxdat_valid, dbf_rxdatflit,
    output rxdat_fifo_cnt, rxdat_fifo_full, rxdat_fifo_ovf
  );
endinterface

// File: rtl/hni_rxdat_fifo.sv
// hni_rxdat_fifo: show-ahead FIFO buffering DAT flits from hni_rxdat toward
// hni_data_buffer. Flits arriving while full (without a simultaneous pop) are
// dropped and latch the sticky overflow flag.
// Optional macro HNI_RXDAT_FIFO_BYPASS_EN: when the FIFO is empty an incoming
// flit is presented on the dbf_* outputs in the same cycle and, if accepted,
// is never written into storage.

`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 64
`endif

module hni_rxdat_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  hni_rxdat_fifo_if.slave  bus
);

  localparam int unsigned W = `CHIE_DAT_FLIT_WIDTH;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ovf;

  logic empty;
  logic full;
  logic pop_mem;
  logic byp_take;
  logic push;
  logic drop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Only a stored head can be popped; ready while empty is ignored.
  assign pop_mem = ~empty & bus.dbf_rxdat_ready;

`ifdef HNI_RXDAT_FIFO_BYPASS_EN
  logic byp;
  // Empty FIFO: incoming flit is shown directly; if taken it skips storage.
  assign byp      = empty & bus.rxdat_valid_s0;
  assign byp_take = byp & bus.dbf_rxdat_ready;
  assign bus.dbf_rxdat_valid = ~empty | byp;
  assign bus.dbf_rxdatflit   = byp   ? bus.rxdatflit_s0 :
                               empty ? '0 : mem[rd_ptr];
`else
  assign byp_take = 1'b0;
  assign bus.dbf_rxdat_valid = ~empty;
  assign bus.dbf_rxdatflit   = empty ? '0 : mem[rd_ptr];
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = bus.rxdat_valid_s0 & (~full | pop_mem) & ~byp_take;
  assign drop = bus.rxdat_valid_s0 & full & ~pop_mem;

  assign bus.rxdat_fifo_cnt  = count;
  assign bus.rxdat_fifo_full = full;
  assign bus.rxdat_fifo_ovf  = ovf;

  // Storage write; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rxdatflit_s0;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop_mem})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hni_rxdat_fifo.sv
// tb_hni_rxdat_fifo: directed, self-checking bench for hni_rxdat_fifo with
// FIFO_DEPTH=4. Expectations follow the build: with HNI_RXDAT_FIFO_BYPASS_EN
// defined, empty-FIFO flits appear in the same cycle.

`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 64
`endif

module tb_hni_rxdat_fifo;

  localparam int unsigned W = `CHIE_DAT_FLIT_WIDTH;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  hni_rxdat_fifo_if #(.PTR_W(2)) bus ();

  hni_rxdat_fifo #(
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rxdat_valid_s0  = 1'b0;
    bus.rxdatflit_s0    = '0;
    bus.dbf_rxdat_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.dbf_rxdat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.dbf_rxdat_valid); end
    n_chk++; if (bus.dbf_rxdatflit !== '0) begin n_fail++; $display("FAIL reset_flit got %0h want 0", bus.dbf_rxdatflit); end
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.rxdat_fifo_cnt); end
    n_chk++; if (bus.rxdat_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.rxdat_fifo_full); end
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", bus.rxdat_fifo_ovf); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_order();
    logic [W-1:0] f [3];
    f[0] = W'(32'hA000_000A);
    f[1] = W'(32'hB000_000B);
    f[2] = W'(32'hC000_000C);
    for (int i = 0; i < 3; i++) begin
      bus.rxdat_valid_s0 = 1'b1;
      bus.rxdatflit_s0   = f[i];
      tick();
      n_chk++; if (bus.rxdat_fifo_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL order_fill_cnt[%0d] got %0d want %0d", i, bus.rxdat_fifo_cnt, i + 1); end
    end
    idle_inputs();
    n_chk++; if (bus.dbf_rxdatflit !== f[0]) begin n_fail++; $display("FAIL order_head got %0h want %0h", bus.dbf_rxdatflit, f[0]); end
    bus.dbf_rxdat_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.dbf_rxdat_valid !== 1'b1 || bus.dbf_rxdatflit !== f[i]) begin n_fail++; $display("FAIL order_out[%0d] got v=%0b %0h want v=1 %0h", i, bus.dbf_rxdat_valid, bus.dbf_rxdatflit, f[i]); end
      tick();
    end
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0 || bus.dbf_rxdat_valid !== 1'b0) begin n_fail++; $display("FAIL order_drained got cnt=%0d v=%0b want cnt=0 v=0", bus.rxdat_fifo_cnt, bus.dbf_rxdat_valid); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      bus.rxdat_valid_s0 = 1'b1;
      bus.rxdatflit_s0   = W'(32'h1100_0000 + i);
      tick();
    end
    n_chk++; if (bus.rxdat_fifo_full !== 1'b1 || bus.rxdat_fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_full got full=%0b cnt=%0d want full=1 cnt=4", bus.rxdat_fifo_full, bus.rxdat_fifo_cnt); end
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop got %0b want 0", bus.rxdat_fifo_ovf); end
    bus.rxdatflit_s0 = W'(32'h1100_0005);
    tick();
    idle_inputs();
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", bus.rxdat_fifo_ovf); end
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt got %0d want 4", bus.rxdat_fifo_cnt); end
    n_chk++; if (bus.dbf_rxdatflit !== W'(32'h1100_0001)) begin n_fail++; $display("FAIL ovf_head got %0h want 11000001", bus.dbf_rxdatflit); end
    tick();
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", bus.rxdat_fifo_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_q [4];
    for (int i = 1; i <= 4; i++) begin
      bus.rxdat_valid_s0 = 1'b1;
      bus.rxdatflit_s0   = W'(32'h2200_0000 + i);
      tick();
    end
    bus.rxdatflit_s0    = W'(32'h2200_00EE);
    bus.dbf_rxdat_ready = 1'b1;
    tick();
    bus.rxdat_valid_s0 = 1'b0;
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd4 || bus.rxdat_fifo_full !== 1'b1) begin n_fail++; $display("FAIL fpp_cnt got cnt=%0d full=%0b want cnt=4 full=1", bus.rxdat_fifo_cnt, bus.rxdat_fifo_full); end
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %0b want 0", bus.rxdat_fifo_ovf); end
    exp_q[0] = W'(32'h2200_0002);
    exp_q[1] = W'(32'h2200_0003);
    exp_q[2] = W'(32'h2200_0004);
    exp_q[3] = W'(32'h2200_00EE);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.dbf_rxdat_valid !== 1'b1 || bus.dbf_rxdatflit !== exp_q[i]) begin n_fail++; $display("FAIL fpp_out[%0d] got v=%0b %0h want v=1 %0h", i, bus.dbf_rxdat_valid, bus.dbf_rxdatflit, exp_q[i]); end
      tick();
    end
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL fpp_drained got %0d want 0", bus.rxdat_fifo_cnt); end
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [W-1:0] s;
    bus.dbf_rxdat_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s = W'(32'h3300_0000 + k * 32'h11);
      bus.rxdat_valid_s0 = 1'b1;
      bus.rxdatflit_s0   = s;
`ifdef HNI_RXDAT_FIFO_BYPASS_EN
      #1;
      n_chk++; if (bus.dbf_rxdat_valid !== 1'b1 || bus.dbf_rxdatflit !== s) begin n_fail++; $display("FAIL stream_byp[%0d] got v=%0b %0h want v=1 %0h", k, bus.dbf_rxdat_valid, bus.dbf_rxdatflit, s); end
      tick();
      n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL stream_cnt[%0d] got %0d want 0", k, bus.rxdat_fifo_cnt); end
`else
      tick();
      n_chk++; if (bus.dbf_rxdat_valid !== 1'b1 || bus.dbf_rxdatflit !== s) begin n_fail++; $display("FAIL stream_out[%0d] got v=%0b %0h want v=1 %0h", k, bus.dbf_rxdat_valid, bus.dbf_rxdatflit, s); end
      n_chk++; if (bus.rxdat_fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL stream_cnt[%0d] got %0d want 1", k, bus.rxdat_fifo_cnt); end
`endif
    end
    bus.rxdat_valid_s0 = 1'b0;
    tick();
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0 || bus.dbf_rxdat_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got cnt=%0d v=%0b want cnt=0 v=0", bus.rxdat_fifo_cnt, bus.dbf_rxdat_valid); end
    idle_inputs();
  endtask

  task automatic test_empty_ready();
    bus.rxdat_valid_s0  = 1'b1;
    bus.rxdatflit_s0    = W'(8'h5A);
    bus.dbf_rxdat_ready = 1'b1;
    #1;
`ifdef HNI_RXDAT_FIFO_BYPASS_EN
    n_chk++; if (bus.dbf_rxdat_valid !== 1'b1 || bus.dbf_rxdatflit !== W'(8'h5A)) begin n_fail++; $display("FAIL byp_same_cycle got v=%0b %0h want v=1 5a", bus.dbf_rxdat_valid, bus.dbf_rxdatflit); end
    tick();
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL byp_taken_cnt got %0d want 0", bus.rxdat_fifo_cnt); end
    bus.dbf_rxdat_ready = 1'b0;
    tick();
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd1 || bus.dbf_rxdatflit !== W'(8'h5A)) begin n_fail++; $display("FAIL byp_held got cnt=%0d %0h want cnt=1 5a", bus.rxdat_fifo_cnt, bus.dbf_rxdatflit); end
`else
    n_chk++; if (bus.dbf_rxdat_valid !== 1'b0 || bus.dbf_rxdatflit !== '0) begin n_fail++; $display("FAIL nobyp_comb got v=%0b %0h want v=0 0", bus.dbf_rxdat_valid, bus.dbf_rxdatflit); end
    tick();
    bus.rxdat_valid_s0  = 1'b0;
    bus.dbf_rxdat_ready = 1'b0;
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd1 || bus.dbf_rxdatflit !== W'(8'h5A)) begin n_fail++; $display("FAIL empty_ready_ignored got cnt=%0d %0h want cnt=1 5a", bus.rxdat_fifo_cnt, bus.dbf_rxdatflit); end
`endif
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.rxdat_valid_s0 = 1'b1;
    bus.rxdatflit_s0   = W'(32'h4400_0001);
    tick();
    bus.rxdatflit_s0   = W'(32'h4400_0002);
    tick();
    idle_inputs();
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd2) begin n_fail++; $display("FAIL areset_pre_cnt got %0d want 2", bus.rxdat_fifo_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.dbf_rxdat_valid !== 1'b0 || bus.rxdat_fifo_cnt !== 3'd0 || bus.rxdat_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL areset_now got v=%0b cnt=%0d ovf=%0b want 0 0 0", bus.dbf_rxdat_valid, bus.rxdat_fifo_cnt, bus.rxdat_fifo_ovf); end
    #1;
    rst_n = 1'b1;
    bus.rxdat_valid_s0 = 1'b1;
    bus.rxdatflit_s0   = W'(32'h4400_00AB);
    tick();
    idle_inputs();
    n_chk++; if (bus.rxdat_fifo_cnt !== 3'd1 || bus.dbf_rxdatflit !== W'(32'h4400_00AB)) begin n_fail++; $display("FAIL areset_repush got cnt=%0d %0h want cnt=1 440000ab", bus.rxdat_fifo_cnt, bus.dbf_rxdatflit); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_order();
    test_overflow();
    apply_reset();
    n_chk++; if (bus.rxdat_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %0b want 0", bus.rxdat_fifo_ovf); end
    test_full_push_pop();
    test_stream();
    test_empty_ready();
    apply_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
